// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the sequential shift-add multiplier: state encoding and default width.
package shift_add_multiplier_pkg;

  localparam int MUL_DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/shift_add_multiplier_add_stage.sv
// mul_add_stage: combinational WIDTH-bit ripple adder, carry-in tied low, carry-out exposed.
module mul_add_stage #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  logic [WIDTH:0] w_c;

  assign w_c[0] = 1'b0;

  for (genvar g = 0; g < WIDTH; g++) begin : g_fa
    assign o_sum[g]   = i_a[g] ^ i_b[g] ^ w_c[g];
    assign w_c[g + 1] = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
  end

  assign o_cout = w_c[WIDTH];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned WIDTHxWIDTH shift-add multiplier, one add-and-shift per clock.
// Optional MUL_ZERO_BYPASS_EN: a zero operand skips the iterations and completes in one cycle.
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH = MUL_DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] Product,
  output logic               Busy,
  output logic               Done
);

  localparam int CW = $clog2(WIDTH + 1);

  mul_state_t       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH:0]   r_acc_hi;
  logic [WIDTH-1:0] r_acc_lo;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] w_addend;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic [WIDTH:0]   w_hi_nxt;
  logic [WIDTH-1:0] w_lo_nxt;
  logic             w_last;
  logic             w_bypass;
  logic             w_unused_hi_msb;

`ifdef MUL_ZERO_BYPASS_EN
  assign w_bypass = (A == '0) || (B == '0);
`else
  assign w_bypass = 1'b0;
`endif

  assign w_addend = r_acc_lo[0] ? r_mcand : '0;

  mul_add_stage #(.WIDTH(WIDTH)) u_add (
    .i_a    (r_acc_hi[WIDTH-1:0]),
    .i_b    (w_addend),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // {carry, sum, acc_lo} >> 1: carry lands in acc_hi[WIDTH-1], so acc_hi[WIDTH] is always 0 after a shift
  assign w_hi_nxt        = {1'b0, w_cout, w_sum[WIDTH-1:1]};
  assign w_lo_nxt        = {w_sum[0], r_acc_lo[WIDTH-1:1]};
  assign w_last          = (r_cnt == CW'(1));
  assign w_unused_hi_msb = r_acc_hi[WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (Start) w_state_nxt = w_bypass ? DONE : RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand  <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_cnt    <= '0;
      Product  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (Start) begin
            if (w_bypass) begin
              Product <= '0;
            end else begin
              r_mcand  <= A;
              r_acc_hi <= '0;
              r_acc_lo <= B;
              r_cnt    <= CW'(WIDTH);
            end
          end
        end
        RUN: begin
          r_acc_hi <= w_hi_nxt;
          r_acc_lo <= w_lo_nxt;
          r_cnt    <= r_cnt - CW'(1);
          if (w_last) Product <= {w_hi_nxt[WIDTH-1:0], w_lo_nxt};
        end
        default: ;
      endcase
    end
  end

  assign Busy = (r_state != IDLE);
  assign Done = (r_state == DONE);

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier: stimulus pushes expected products, a monitor checks Done.
module tb_shift_add_multiplier;

  localparam int W = 4;

  typedef struct {
    logic [31:0] prod;
    int          cyc;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           Start = 1'b0;
  logic [W-1:0]   A = '0;
  logic [W-1:0]   B = '0;
  logic [2*W-1:0] Product;
  logic           Busy;
  logic           Done;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .Start   (Start),
    .A       (A),
    .B       (B),
    .Product (Product),
    .Busy    (Busy),
    .Done    (Done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every Done cycle must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && Done) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_done: got Done=1 expected no pending result (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        chk("product", 32'(Product), e.prod);
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  function automatic int lat(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MUL_ZERO_BYPASS_EN
    if (a == '0 || b == '0) return 1;
`endif
    return W;
  endfunction

  // Pulse Start for one edge; returns at the negedge after the accepting edge with k = that edge number
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [31:0] prod,
                       input bit push, output int k);
    exp_t e;
    @(negedge clk);
    Start = 1'b1; A = a; B = b;
    @(negedge clk);
    k = cyc;
    Start = 1'b0; A = ~a; B = ~b;
    if (push) begin
      e.prod = prod;
      e.cyc  = k + lat(a, b);
      q.push_back(e);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((Busy || q.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got Busy=%0b pending=%0d expected idle within 60 cycles", name, Busy, q.size());
    end
    @(negedge clk);
  endtask

  initial begin
    int   k;
    exp_t e;

    repeat (2) @(negedge clk);
    chk("rst_product", 32'(Product), 0);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_done", 32'(Done), 0);
    rst = 1'b0;
    @(negedge clk);

    // 3*5, with Busy window check
    issue(4'd3, 4'd5, 32'h0F, 1'b1, k);
    chk("busy_after_accept", 32'(Busy), 1);
    repeat (W) @(negedge clk);
    chk("busy_in_done", 32'(Busy), 1);
    @(negedge clk);
    chk("busy_after_done", 32'(Busy), 0);
    wait_idle("op_3x5");

    issue(4'd15, 4'd15, 32'hE1, 1'b1, k);
    wait_idle("op_15x15");

    issue(4'd0, 4'd9, 32'h00, 1'b1, k);
    wait_idle("op_0x9");

    issue(4'd13, 4'd0, 32'h00, 1'b1, k);
    wait_idle("op_13x0");

    // Second request during RUN must be dropped
    issue(4'd7, 4'd6, 32'h2A, 1'b1, k);
    @(negedge clk);
    Start = 1'b1; A = 4'd1; B = 4'd1;
    @(negedge clk);
    Start = 1'b0;
    wait_idle("op_ignore");

    // Abort mid-RUN: outputs clear at once, no Done
    issue(4'd9, 4'd11, 32'h63, 1'b0, k);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_product", 32'(Product), 0);
    chk("abort_busy", 32'(Busy), 0);
    chk("abort_done", 32'(Done), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (W + 2) @(negedge clk);
    issue(4'd9, 4'd11, 32'h63, 1'b1, k);
    wait_idle("op_9x11");

    // Start held high: a result every W+2 cycles
    Start = 1'b1; A = 4'd2; B = 4'd3;
    k = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      e.prod = 32'h06;
      e.cyc  = k + W + i * (W + 2);
      q.push_back(e);
    end
    repeat (2 * (W + 2) + 2) @(negedge clk);
    Start = 1'b0;
    wait_idle("op_held");

    chk("queue_drained", 32'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
